// File: rtl/enemy_hit_tracker_if.sv
// Formation/bullet/raster inputs and hit/score/render outputs of the enemy hit tracker.
// Signal names match the original port list so the bundle stays a drop-in replacement.
interface enemy_hit_tracker_if #(
    parameter int ROWS = 4,
    parameter int COLS = 8
);
    localparam int IDX_W = $clog2(ROWS * COLS);
    localparam int CNT_W = $clog2(ROWS * COLS + 1);

    logic             frame_clk;
    logic             Start;
    logic [9:0]       L_Edge;
    logic [9:0]       U_Edge;
    logic [9:0]       bullet_x;
    logic [9:0]       bullet_y;
    logic             bullet_valid;
    logic [9:0]       DrawX;
    logic [9:0]       DrawY;
    logic             enemy_on;
    logic             hit;
    logic [IDX_W-1:0] hit_index;
    logic             bullet_kill;
    logic [15:0]      score;
    logic [CNT_W-1:0] alive_count;
    logic             all_dead;

    modport master (
        output frame_clk, Start, L_Edge, U_Edge, bullet_x, bullet_y, bullet_valid, DrawX, DrawY,
        input  enemy_on, hit, hit_index, bullet_kill, score, alive_count, all_dead
    );

    modport slave (
        input  frame_clk, Start, L_Edge, U_Edge, bullet_x, bullet_y, bullet_valid, DrawX, DrawY,
        output enemy_on, hit, hit_index, bullet_kill, score, alive_count, all_dead
    );
endinterface

// File: rtl/enemy_hit_tracker.sv
// Enemy grid alive mask: one bullet collision check per frame, kill/score bookkeeping,
// and a registered per-pixel enemy_on for the colour mapper.
module enemy_hit_tracker #(
    parameter int ROWS        = 4,
    parameter int COLS        = 8,
    parameter int CELL_W_LOG2 = 5,
    parameter int CELL_H_LOG2 = 5,
    parameter int SPR_W       = 24,
    parameter int SPR_H       = 16,
    parameter int POINTS      = 10
) (
    input  logic                Clk,
    input  logic                Reset,
    enemy_hit_tracker_if.slave  bus
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CLEAR} state_t;

    state_t           r_state, w_next;
    logic             r_f0, r_f1, r_tick;
    logic [9:0]       r_bx, r_by, r_lx, r_uy;
    logic [N-1:0]     r_alive;
    logic [IDX_W-1:0] r_idx, r_hit_index;
    logic             r_hit, r_bullet_kill, r_enemy_on, r_all_dead;
    logic [15:0]      r_score;
    logic [CNT_W-1:0] r_count;
    logic [IDX_W:0]   w_chk, w_draw;
    logic [16:0]      w_sum;

    // Returns {live-sprite hit, linear cell index}; 11-bit signed offsets keep edges near 0 from wrapping.
    function automatic logic [IDX_W:0] f_geo(input logic [9:0] px, input logic [9:0] py,
                                             input logic [9:0] ex, input logic [9:0] ey,
                                             input logic [N-1:0] mask);
        logic signed [10:0] dx, dy;
        logic [10:0]        col, row;
        logic [IDX_W-1:0]   idx;
        logic               ok;
        dx  = $signed({1'b0, px}) - $signed({1'b0, ex});
        dy  = $signed({1'b0, py}) - $signed({1'b0, ey});
        col = $unsigned(dx) >> CELL_W_LOG2;
        row = $unsigned(dy) >> CELL_H_LOG2;
        ok  = !dx[10] && !dy[10] && (32'(col) < COLS) && (32'(row) < ROWS)
              && (32'(dx[CELL_W_LOG2-1:0]) < SPR_W) && (32'(dy[CELL_H_LOG2-1:0]) < SPR_H);
        idx = IDX_W'(32'(row) * COLS + 32'(col));
        return {ok && mask[idx], idx};
    endfunction

    assign w_chk  = f_geo(r_bx, r_by, r_lx, r_uy, r_alive);
    assign w_draw = f_geo(bus.DrawX, bus.DrawY, bus.L_Edge, bus.U_Edge, r_alive);
    assign w_sum  = {1'b0, r_score} + 17'(POINTS);

    always_ff @(posedge Clk) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!bus.Start && r_tick && bus.bullet_valid) w_next = S_CHECK;
            S_CHECK: w_next = w_chk[IDX_W] ? S_CLEAR : S_IDLE;
            S_CLEAR: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_f0          <= 1'b0;
            r_f1          <= 1'b0;
            r_tick        <= 1'b0;
            r_bx          <= '0;
            r_by          <= '0;
            r_lx          <= '0;
            r_uy          <= '0;
            r_alive       <= '1;
            r_idx         <= '0;
            r_hit_index   <= '0;
            r_hit         <= 1'b0;
            r_bullet_kill <= 1'b0;
            r_enemy_on    <= 1'b0;
            r_all_dead    <= 1'b0;
            r_score       <= '0;
            r_count       <= CNT_W'(N);
        end else begin
            r_f0          <= bus.frame_clk;
            r_f1          <= r_f0;
            r_tick        <= r_f0 & ~r_f1;
            r_hit         <= 1'b0;
            r_bullet_kill <= 1'b0;
            r_enemy_on    <= w_draw[IDX_W];
            case (r_state)
                S_IDLE: begin
                    if (bus.Start) begin
                        r_alive    <= '1;
                        r_count    <= CNT_W'(N);
                        r_all_dead <= 1'b0;
                    end else if (r_tick && bus.bullet_valid) begin
                        r_bx <= bus.bullet_x;
                        r_by <= bus.bullet_y;
                        r_lx <= bus.L_Edge;
                        r_uy <= bus.U_Edge;
                    end
                end
                S_CHECK: r_idx <= w_chk[IDX_W-1:0];
                S_CLEAR: begin
                    r_alive[r_idx] <= 1'b0;
                    r_hit          <= 1'b1;
                    r_bullet_kill  <= 1'b1;
                    r_hit_index    <= r_idx;
                    r_score        <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
                    r_count        <= r_count - 1'b1;
                    r_all_dead     <= (r_count == CNT_W'(1));
                end
                default: ;
            endcase
        end
    end

    assign bus.enemy_on    = r_enemy_on;
    assign bus.hit         = r_hit;
    assign bus.hit_index   = r_hit_index;
    assign bus.bullet_kill = r_bullet_kill;
    assign bus.score       = r_score;
    assign bus.alive_count = r_count;
    assign bus.all_dead    = r_all_dead;
endmodule

// File: tb/tb_enemy_hit_tracker.sv
// Directed bench for enemy_hit_tracker: kills, misses, wave restart, reset mid-check, render path.
module tb_enemy_hit_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    enemy_hit_tracker_if #(.ROWS(4), .COLS(8)) bus ();

    enemy_hit_tracker #(
        .ROWS(4), .COLS(8), .CELL_W_LOG2(5), .CELL_H_LOG2(5),
        .SPR_W(24), .SPR_H(16), .POINTS(10)
    ) dut (
        .Clk  (clk),
        .Reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One frame_clk pulse; first = negedge index (0 = right after the edge that first samples it high).
    task automatic do_frame(input logic [9:0] bx, input logic [9:0] by, input logic v,
                            output int pulses, output int first, output logic [4:0] idx,
                            output int bk_bad);
        bus.bullet_x     = bx;
        bus.bullet_y     = by;
        bus.bullet_valid = v;
        @(negedge clk);
        bus.frame_clk = 1'b1;
        pulses = 0; first = -1; idx = '0; bk_bad = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.hit) begin
                pulses++;
                if (first < 0) first = i;
                idx = bus.hit_index;
            end
            if (bus.hit !== bus.bullet_kill) bk_bad++;
            if (i == 5) bus.frame_clk = 1'b0;
        end
    endtask

    int         p, f, bk;
    logic [4:0] ix;
    int         hits_in_reset;

    initial begin
        bus.frame_clk = 0; bus.Start = 0; bus.L_Edge = 10'd100; bus.U_Edge = 10'd40;
        bus.bullet_x = 0; bus.bullet_y = 0; bus.bullet_valid = 0;
        bus.DrawX = 10'd1000; bus.DrawY = 10'd1000;

        hits_in_reset = 0;
        repeat (2) begin
            @(negedge clk);
            if (bus.hit) hits_in_reset++;
        end
        rst = 1'b0;
        check("rst_alive", 32'(bus.alive_count), 32);
        check("rst_score", 32'(bus.score), 0);
        check("rst_all_dead", 32'(bus.all_dead), 0);
        check("rst_enemy_on", 32'(bus.enemy_on), 0);
        check("rst_hit", 32'(hits_in_reset + int'(bus.hit)), 0);

        do_frame(10'd110, 10'd50, 1'b1, p, f, ix, bk);
        check("k0_pulses", 32'(p), 1);
        check("k0_latency", 32'(f), 4);
        check("k0_idx", 32'(ix), 0);
        check("k0_bk", 32'(bk), 0);
        check("k0_score", 32'(bus.score), 10);
        check("k0_alive", 32'(bus.alive_count), 31);

        do_frame(10'd110, 10'd50, 1'b1, p, f, ix, bk);
        check("dead_pulses", 32'(p), 0);
        check("dead_score", 32'(bus.score), 10);

        do_frame(10'd347, 10'd151, 1'b1, p, f, ix, bk);
        check("k31_pulses", 32'(p), 1);
        check("k31_idx", 32'(ix), 31);
        check("k31_alive", 32'(bus.alive_count), 30);

        do_frame(10'd124, 10'd50, 1'b1, p, f, ix, bk);
        check("gap_x", 32'(p), 0);
        do_frame(10'd99, 10'd50, 1'b1, p, f, ix, bk);
        check("neg_dx", 32'(p), 0);
        do_frame(10'd137, 10'd50, 1'b0, p, f, ix, bk);
        check("not_valid", 32'(p), 0);
        check("miss_score", 32'(bus.score), 20);

        for (int k = 1; k <= 30; k++) begin
            do_frame(10'(100 + (k % 8) * 32 + 3), 10'(40 + (k / 8) * 32 + 3), 1'b1, p, f, ix, bk);
            check("sweep_pulses", 32'(p), 1);
            check("sweep_idx", 32'(ix), 32'(k));
            if (k == 29) begin
                check("one_left_alive", 32'(bus.alive_count), 1);
                check("one_left_dead", 32'(bus.all_dead), 0);
            end
        end
        check("all_alive", 32'(bus.alive_count), 0);
        check("all_dead", 32'(bus.all_dead), 1);
        check("all_score", 32'(bus.score), 320);

        @(negedge clk); bus.Start = 1'b1;
        @(negedge clk); bus.Start = 1'b0;
        check("start_alive", 32'(bus.alive_count), 32);
        check("start_dead", 32'(bus.all_dead), 0);
        check("start_score", 32'(bus.score), 320);

        bus.Start = 1'b1;
        do_frame(10'd110, 10'd50, 1'b1, p, f, ix, bk);
        bus.Start = 1'b0;
        check("start_beats_tick", 32'(p), 0);
        check("start_mask_full", 32'(bus.alive_count), 32);

        // Reset sampled on the edge that would leave CHECK.
        bus.bullet_x = 10'd110; bus.bullet_y = 10'd50; bus.bullet_valid = 1'b1;
        @(negedge clk);
        bus.frame_clk = 1'b1;
        p = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.hit || bus.bullet_kill) p++;
            if (i == 2) begin rst = 1'b1; bus.frame_clk = 1'b0; end
            if (i == 3) rst = 1'b0;
        end
        check("rchk_no_hit", 32'(p), 0);
        check("rchk_score", 32'(bus.score), 0);
        check("rchk_alive", 32'(bus.alive_count), 32);
        check("rchk_dead", 32'(bus.all_dead), 0);
        check("rchk_hit_index", 32'(bus.hit_index), 0);
        do_frame(10'd110, 10'd50, 1'b1, p, f, ix, bk);
        check("rchk_next_latency", 32'(f), 4);

        do_reset();
        bus.L_Edge = 10'd0; bus.U_Edge = 10'd0;
        bus.DrawX = 10'd1000; bus.DrawY = 10'd1000;
        repeat (2) @(negedge clk);
        check("rnd_far", 32'(bus.enemy_on), 0);
        bus.DrawX = 10'd5; bus.DrawY = 10'd5;
        #1 check("rnd_reg_lat", 32'(bus.enemy_on), 0);
        @(negedge clk);
        check("rnd_on", 32'(bus.enemy_on), 1);
        do_frame(10'd5, 10'd5, 1'b1, p, f, ix, bk);
        check("rnd_kill", 32'(p), 1);
        check("rnd_killed_off", 32'(bus.enemy_on), 0);
        bus.DrawX = 10'd30;
        @(negedge clk);
        check("rnd_gap", 32'(bus.enemy_on), 0);
        bus.DrawX = 10'd37;
        @(negedge clk);
        check("rnd_col1", 32'(bus.enemy_on), 1);
        bus.L_Edge = 10'd1020; bus.DrawX = 10'd2;
        @(negedge clk);
        check("rnd_no_wrap", 32'(bus.enemy_on), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
